lsu_sram_resp: RTL and testbench
================================

LSU_SRAM_RESP -- requirements
Module: lsu_sram_resp

Interface
REQ-001 SHALL have parameter DEPTH, 1024, number of 64-bit words stored.
REQ-002 SHALL have parameter LATENCY, 2, cycles from request acceptance to response valid; legal range 1..15.
REQ-003 SHALL have parameter BASE_ADDR, 32'h8000_0000, byte address of word 0.
REQ-004 SHALL have port clk  input  1  the single clock.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port req_valid  input  1  the core presents a request.
REQ-007 SHALL have port req_ready  output  1  the block accepts a request.
REQ-008 SHALL have port req_addr  input  32  byte address; bits [2:0] are ignored.
REQ-009 SHALL have port req_wen  input  1  1 = store, 0 = load.
REQ-010 SHALL have port req_wdata  input  64  store data.
REQ-011 SHALL have port req_wmask  input  8  byte enables; bit i covers wdata[8i+7:8i].
REQ-012 SHALL have port resp_valid  output  1  response is present.
REQ-013 SHALL have port resp_ready  input  1  the core accepts the response.
REQ-014 SHALL have port resp_rdata  output  64  load data; 0 for stores and errors.
REQ-015 SHALL have port resp_err  output  1  address was out of range.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-017 SHALL assert req_ready only in IDLE; a handshake occurs when req_valid && req_ready is high at a rising clk edge.
REQ-018 SHALL, on a handshake in IDLE, latch addr/wen/wdata/wmask, load the latency counter with LATENCY-1 and go to WAIT, or go straight to RESP when LATENCY = 1.
REQ-019 SHALL decrement the counter in WAIT and go to RESP when the counter equals 0.
REQ-020 SHALL compute the word index as (addr - BASE_ADDR) >> 3.
REQ-021 SHALL treat a request as in range only when addr >= BASE_ADDR and index < DEPTH, using unsigned 32-bit compares with no wrap-around.
REQ-022 SHALL perform an in-range store on the WAIT->RESP (or IDLE->RESP) transition, writing only the masked bytes; wmask = 0 writes nothing and still responds.
REQ-023 SHALL set resp_rdata, for an in-range load, to the full 64-bit word read at the same transition.
REQ-024 SHALL, for an out-of-range request, set resp_err = 1 and resp_rdata = 0 and leave storage unmodified.
REQ-025 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_ready = 1, then return to IDLE on that edge.
REQ-026 SHALL NOT accept a new request in the cycle of the RESP->IDLE transition; the minimum request spacing is LATENCY + 1 cycles.
REQ-027 SHALL ignore req_* inputs outside IDLE.
REQ-028 SHALL reflect a store in a load to the same address accepted after the store's response.

Reset
REQ-029 SHALL, while rst = 1 at a clk edge, enter IDLE, clear the counter and drive req_ready = 1 (the first cycle after reset), resp_valid = 0, resp_rdata = 0 and resp_err = 0.
REQ-030 SHALL abort any in-flight request when rst is asserted mid-operation; a store not yet committed SHALL NOT be written.
REQ-031 SHALL NOT clear storage contents on reset.

Structure
REQ-032 SHALL place the FSM state encoding (2-bit) and the default BASE_ADDR constant in the shared defines file alongside the existing CPU_WIDTH definitions.
REQ-033 SHALL use one sub-module, sram_bytemask, a DEPTH x 64 synchronous array with per-byte write enable; the FSM, counter and range check stay in the top level.

Verification
REQ-034 SHALL cover a store then load: store 0x8000_0010, wdata 0x1122334455667788, wmask 0xFF, then a load from the same address -> resp_rdata = 0x1122334455667788 and resp_err = 0, with resp_valid exactly LATENCY cycles after each handshake.
REQ-035 SHALL cover a partial store: word holds 0xFFFF..FF, store wdata 0, wmask 0x0F, then a load -> 0xFFFFFFFF00000000.
REQ-036 SHALL cover out-of-range requests: load 0x7FFF_FFF8 and load BASE + 8*DEPTH -> resp_err = 1 and rdata = 0; a store to BASE + 8*DEPTH leaves word 0 and word DEPTH-1 unchanged.
REQ-037 SHALL cover backpressure: resp_ready held low 5 cycles -> resp_valid, rdata and err stable and req_ready = 0 throughout; IDLE is reached on the edge where resp_ready = 1.
REQ-038 SHALL cover reset mid-store: rst asserted in WAIT -> next cycle resp_valid = 0 and req_ready = 1, and a later load shows the old data.
REQ-039 SHALL cover LATENCY = 1: back-to-back requests with resp_ready = 1 -> one response every 2 cycles.

Source files
------------

// File: rtl/lsu_sram_resp_pkg.sv
// Shared defines for the LSU SRAM responder: CPU data widths, FSM encoding
// and the default base address of the scratchpad.
package lsu_sram_resp_pkg;

    localparam int unsigned CPU_WIDTH = 64;
    localparam int unsigned CPU_STRB  = CPU_WIDTH / 8;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/lsu_sram_resp_sram_bytemask.sv
// DEPTH x 64 synchronous single-port array with per-byte write enables.
// Read data is registered and holds its value until the next read.
module sram_bytemask
    import lsu_sram_resp_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 we,
    input  logic [AW-1:0]        addr,
    input  logic [CPU_WIDTH-1:0] wdata,
    input  logic [CPU_STRB-1:0]  wmask,
    output logic [CPU_WIDTH-1:0] rdata
);

    logic [CPU_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int unsigned i = 0; i < CPU_STRB; i++) begin
                    if (wmask[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/lsu_sram_resp.sv
// LSU-facing SRAM responder: accepts one request at a time, waits LATENCY
// cycles, commits the access and holds the response until the core takes it.
module lsu_sram_resp
    import lsu_sram_resp_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    lsu_state_e  state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic        enter_resp;

    logic [31:0] addr_q;
    logic        wen_q;
    logic [63:0] wdata_q;
    logic [7:0]  wmask_q;
    logic        err_q;

    logic        idle_st;
    logic [31:0] op_addr;
    logic        op_wen;
    logic [63:0] op_wdata;
    logic [7:0]  op_wmask;
    logic [31:0] offset;
    logic [31:0] word_idx;
    logic        in_range;
    logic        mem_en;
    logic [63:0] sram_rdata;

    // With LATENCY = 1 the commit happens on the accepting edge itself, so the
    // array is fed from the live request rather than the latched copy.
    assign idle_st  = (state == IDLE);
    assign op_addr  = idle_st ? req_addr  : addr_q;
    assign op_wen   = idle_st ? req_wen   : wen_q;
    assign op_wdata = idle_st ? req_wdata : wdata_q;
    assign op_wmask = idle_st ? req_wmask : wmask_q;

    assign offset   = op_addr - BASE_ADDR;
    assign word_idx = offset >> 3;
    assign in_range = (op_addr >= BASE_ADDR) && (word_idx < DEPTH);
    assign mem_en   = enter_resp && in_range && !rst;

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt - 4'd1;
                if (cnt_d == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (idle_st && req_valid) begin
                addr_q  <= req_addr;
                wen_q   <= req_wen;
                wdata_q <= req_wdata;
                wmask_q <= req_wmask;
            end
            if (enter_resp) begin
                err_q <= !in_range;
            end
        end
    end

    sram_bytemask #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sram (
        .clk   (clk),
        .en    (mem_en),
        .we    (op_wen),
        .addr  (word_idx[AW-1:0]),
        .wdata (op_wdata),
        .wmask (op_wmask),
        .rdata (sram_rdata)
    );

    assign req_ready  = idle_st;
    assign resp_valid = (state == RESP);
    assign resp_err   = (state == RESP) && err_q;
    assign resp_rdata = ((state == RESP) && !err_q && !wen_q) ? sram_rdata : '0;

endmodule

// File: tb/tb_lsu_sram_resp.sv
// Directed bench for lsu_sram_resp: LATENCY=2/DEPTH=1024 instance for the
// main scenarios, LATENCY=1/DEPTH=16 instance for back-to-back traffic.
module tb_lsu_sram_resp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_ready, req_wen, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr;
    logic [63:0] req_wdata, resp_rdata;
    logic [7:0]  req_wmask;

    logic        req_valid1, req_ready1, req_wen1, resp_valid1, resp_ready1, resp_err1;
    logic [31:0] req_addr1;
    logic [63:0] req_wdata1, resp_rdata1;
    logic [7:0]  req_wmask1;

    int errors = 0;
    int checks = 0;

    lsu_sram_resp #(.DEPTH(1024), .LATENCY(2), .BASE_ADDR(32'h8000_0000)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wen(req_wen), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    lsu_sram_resp #(.DEPTH(16), .LATENCY(1), .BASE_ADDR(32'h8000_0000)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1),
        .req_wen(req_wen1), .req_wdata(req_wdata1), .req_wmask(req_wmask1),
        .resp_valid(resp_valid1), .resp_ready(resp_ready1),
        .resp_rdata(resp_rdata1), .resp_err(resp_err1)
    );

    // One transaction on the LATENCY=2 instance; lat counts edges from the
    // accepting edge (1) to the first sample with resp_valid high.
    task automatic do_req(input logic [31:0] a, input logic w, input logic [63:0] d,
                          input logic [7:0] m, output logic [63:0] rd,
                          output logic er, output int lat);
        int guard = 0;
        while (!req_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        req_valid = 1'b1; req_addr = a; req_wen = w; req_wdata = d; req_wmask = m;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        rd = resp_rdata;
        er = resp_err;
        if (resp_valid) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        checks++; if (resp_rdata !== 64'h0) begin errors++; $display("FAIL reset_resp_rdata: got %h expected 0", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b expected 0", resp_err); end
        checks++; if (req_ready1 !== 1'b1) begin errors++; $display("FAIL reset_req_ready_l1: got %b expected 1", req_ready1); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        logic [63:0] rd; logic er; int lat;
        do_req(32'h8000_0010, 1'b1, 64'h1122334455667788, 8'hFF, rd, er, lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL store_latency: got %0d expected 2", lat); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL store_err: got %b expected 0", er); end
        checks++; if (rd !== 64'h0) begin errors++; $display("FAIL store_rdata: got %h expected 0", rd); end
        do_req(32'h8000_0010, 1'b0, 64'h0, 8'h00, rd, er, lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL load_latency: got %0d expected 2", lat); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL load_err: got %b expected 0", er); end
        checks++; if (rd !== 64'h1122334455667788) begin errors++; $display("FAIL load_rdata: got %h expected 1122334455667788", rd); end
    endtask

    task automatic test_partial_store();
        logic [63:0] rd; logic er; int lat;
        do_req(32'h8000_0020, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, er, lat);
        do_req(32'h8000_0020, 1'b1, 64'h0, 8'h0F, rd, er, lat);
        do_req(32'h8000_0020, 1'b0, 64'h0, 8'h00, rd, er, lat);
        checks++; if (rd !== 64'hFFFF_FFFF_0000_0000) begin errors++; $display("FAIL partial_rdata: got %h expected ffffffff00000000", rd); end
        do_req(32'h8000_0020, 1'b1, 64'h1234_5678_9ABC_DEF0, 8'h00, rd, er, lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL zero_mask_latency: got %0d expected 2", lat); end
        do_req(32'h8000_0020, 1'b0, 64'h0, 8'h00, rd, er, lat);
        checks++; if (rd !== 64'hFFFF_FFFF_0000_0000) begin errors++; $display("FAIL zero_mask_rdata: got %h expected ffffffff00000000", rd); end
        do_req(32'h8000_0020, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 8'h81, rd, er, lat);
        do_req(32'h8000_0020, 1'b0, 64'h0, 8'h00, rd, er, lat);
        checks++; if (rd !== 64'hAAFF_FFFF_0000_00DD) begin errors++; $display("FAIL mask81_rdata: got %h expected aaffffff000000dd", rd); end
    endtask

    task automatic test_out_of_range();
        logic [63:0] rd; logic er; int lat;
        do_req(32'h8000_0000, 1'b1, 64'hA0A0_A0A0_A0A0_A0A0, 8'hFF, rd, er, lat);
        do_req(32'h8000_1FF8, 1'b1, 64'hB1B1_B1B1_B1B1_B1B1, 8'hFF, rd, er, lat);
        do_req(32'h7FFF_FFF8, 1'b0, 64'h0, 8'h00, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL below_base_err: got %b expected 1", er); end
        checks++; if (rd !== 64'h0) begin errors++; $display("FAIL below_base_rdata: got %h expected 0", rd); end
        do_req(32'h8000_2000, 1'b0, 64'h0, 8'h00, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL above_top_err: got %b expected 1", er); end
        checks++; if (rd !== 64'h0) begin errors++; $display("FAIL above_top_rdata: got %h expected 0", rd); end
        do_req(32'h8000_2000, 1'b1, 64'hDEAD_DEAD_DEAD_DEAD, 8'hFF, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_store_err: got %b expected 1", er); end
        do_req(32'h8000_0000, 1'b0, 64'h0, 8'h00, rd, er, lat);
        checks++; if (rd !== 64'hA0A0_A0A0_A0A0_A0A0) begin errors++; $display("FAIL word0_rdata: got %h expected a0a0a0a0a0a0a0a0", rd); end
        do_req(32'h8000_1FF8, 1'b0, 64'h0, 8'h00, rd, er, lat);
        checks++; if (rd !== 64'hB1B1_B1B1_B1B1_B1B1) begin errors++; $display("FAIL last_word_rdata: got %h expected b1b1b1b1b1b1b1b1", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL last_word_err: got %b expected 0", er); end
        do_req(32'h8000_0007, 1'b0, 64'h0, 8'h00, rd, er, lat);
        checks++; if (rd !== 64'hA0A0_A0A0_A0A0_A0A0) begin errors++; $display("FAIL low_bits_ignored: got %h expected a0a0a0a0a0a0a0a0", rd); end
    endtask

    task automatic test_backpressure();
        logic [63:0] rd; logic er; int lat; int guard;
        resp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h8000_0010; req_wen = 1'b0; req_wdata = '0; req_wmask = '0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        guard = 0;
        while (!resp_valid && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        // A store presented while the response is held must be ignored.
        req_valid = 1'b1; req_addr = 32'h8000_0010; req_wen = 1'b1; req_wdata = '0; req_wmask = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, resp_valid); end
            checks++; if (resp_rdata !== 64'h1122334455667788) begin errors++; $display("FAIL bp_rdata[%0d]: got %h expected 1122334455667788", i, resp_rdata); end
            checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL bp_err[%0d]: got %b expected 0", i, resp_err); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready[%0d]: got %b expected 0", i, req_ready); end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", resp_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", req_ready); end
        do_req(32'h8000_0010, 1'b0, 64'h0, 8'h00, rd, er, lat);
        checks++; if (rd !== 64'h1122334455667788) begin errors++; $display("FAIL bp_ignored_store: got %h expected 1122334455667788", rd); end
    endtask

    task automatic test_reset_mid_store();
        logic [63:0] rd; logic er; int lat;
        req_valid = 1'b1; req_addr = 32'h8000_0010; req_wen = 1'b1;
        req_wdata = 64'hDEAD_BEEF_CAFE_F00D; req_wmask = 8'hFF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL mid_wait_valid: got %b expected 0", resp_valid); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", resp_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b expected 1", req_ready); end
        rst = 1'b0;
        @(posedge clk); #1;
        do_req(32'h8000_0010, 1'b0, 64'h0, 8'h00, rd, er, lat);
        checks++; if (rd !== 64'h1122334455667788) begin errors++; $display("FAIL mid_rst_old_data: got %h expected 1122334455667788", rd); end
    endtask

    // Requests held continuously on the LATENCY=1 instance: accept, respond,
    // idle, accept again -> responses on every other sample.
    task automatic test_back_to_back();
        resp_ready1 = 1'b1;
        req_valid1 = 1'b1; req_addr1 = 32'h8000_0008; req_wen1 = 1'b1;
        req_wdata1 = 64'h0123_4567_89AB_CDEF; req_wmask1 = 8'hFF;
        @(posedge clk); #1;
        req_wen1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) begin
                checks++; if (resp_valid1 !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b expected 1", k, resp_valid1); end
                checks++; if (req_ready1 !== 1'b0) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected 0", k, req_ready1); end
                if (k == 0) begin
                    checks++; if (resp_rdata1 !== 64'h0) begin errors++; $display("FAIL b2b_store_rdata: got %h expected 0", resp_rdata1); end
                end else begin
                    checks++; if (resp_rdata1 !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL b2b_load_rdata[%0d]: got %h expected 0123456789abcdef", k, resp_rdata1); end
                end
            end else begin
                checks++; if (resp_valid1 !== 1'b0) begin errors++; $display("FAIL b2b_valid[%0d]: got %b expected 0", k, resp_valid1); end
                checks++; if (req_ready1 !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected 1", k, req_ready1); end
            end
            @(posedge clk); #1;
        end
        req_addr1 = 32'h8000_0080;
        // Drain the response in flight, then the next accepted load is out of range.
        while (!req_ready1) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        checks++; if (resp_err1 !== 1'b1) begin errors++; $display("FAIL b2b_oor_err: got %b expected 1", resp_err1); end
        checks++; if (resp_rdata1 !== 64'h0) begin errors++; $display("FAIL b2b_oor_rdata: got %h expected 0", resp_rdata1); end
        req_valid1 = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_wen = 1'b0; req_wdata = '0; req_wmask = '0;
        resp_ready = 1'b1;
        req_valid1 = 1'b0; req_addr1 = '0; req_wen1 = 1'b0; req_wdata1 = '0; req_wmask1 = '0;
        resp_ready1 = 1'b1;
        test_reset();
        test_store_load();
        test_partial_store();
        test_out_of_range();
        test_backpressure();
        test_reset_mid_store();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
